// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light controller and its pedestrian
// request front end, so both sides agree on state names and thresholds.
package traffic_pkg;

    // Pedestrian request handshake states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        ASSERT  = 2'd2,
        HOLDOFF = 2'd3
    } ped_state_t;

    // Countdown value at or below which a green phase counts as shortened.
    localparam int unsigned SHORT_GREEN_DEFAULT = 10;

    // Ceiling of the dropped-press counter.
    localparam logic [7:0] DROPPED_MAX = 8'hFF;

    // Increment that sticks at the ceiling instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == DROPPED_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stability debouncer and rising-edge pulse for a
// bouncing push-button.  press is a one-cycle pulse issued together with
// the 0->1 change of btn_stable.
module btn_debounce
    import traffic_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_stable,
    output logic press
);

    localparam int unsigned       CNT_W    = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    generate
        if (DEB_CYCLES < 2) begin : g_bad_deb
            $error("btn_debounce: DEB_CYCLES must be at least 2");
        end
    endgenerate

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state: shift the synchroniser, count consecutive disagreeing samples,
    // accept the new level on the DEB_CYCLES-th one.
    always_comb begin
        sync1_d  = btn_raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        press_d = stable_d & ~stable_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign btn_stable = stable_q;
    assign press      = press_q;

endmodule

// File: rtl/ped_request_ctrl.sv
// Pedestrian request front end: debounces the button, waits for green,
// holds pass_request until green is shortened or ends, then cools down.
module ped_request_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned DEB_CYCLES     = 16,
    parameter int unsigned HOLDOFF_CYCLES = 200,
    parameter int unsigned SHORT_GREEN    = SHORT_GREEN_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic       green,
    input  logic [7:0] clock,
    output logic       pass_request,
    output logic       req_pending,
    output logic [7:0] dropped_cnt
);

    localparam int unsigned      HO_W           = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [HO_W-1:0]  HO_LOAD        = HO_W'(HOLDOFF_CYCLES - 1);
    localparam logic [7:0]       SHORT_GREEN_TH = SHORT_GREEN[7:0];

    generate
        if (HOLDOFF_CYCLES == 0) begin : g_bad_holdoff
            $error("ped_request_ctrl: HOLDOFF_CYCLES must be non-zero");
        end
    endgenerate

    logic press;
    logic btn_stable_unused;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_btn_debounce (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_stable (btn_stable_unused),
        .press      (press)
    );

    ped_state_t      state_q, state_d;
    logic [HO_W-1:0] hold_q, hold_d;
    logic [7:0]      dropped_q, dropped_d;
    logic            pass_request_q, pass_request_d;
    logic            req_pending_q, req_pending_d;

    // Next-state and output decode; outputs follow the next state so they
    // change on the same edge as the state register.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        dropped_d = dropped_q;
        case (state_q)
            IDLE: begin
                if (press) begin
                    state_d = green ? ASSERT : ARMED;
                end
            end
            ARMED: begin
                if (green) begin
                    state_d = ASSERT;
                end
            end
            ASSERT: begin
                // Already-short green on entry leaves after a single cycle.
                if (!green || (clock <= SHORT_GREEN_TH)) begin
                    state_d = HOLDOFF;
                    hold_d  = HO_LOAD;
                end
            end
            HOLDOFF: begin
                if (hold_q == '0) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Judged on the current state, so a press on the HOLDOFF->IDLE edge is lost.
        if (press && (state_q != IDLE)) begin
            dropped_d = sat_inc8(dropped_q);
        end
        pass_request_d = (state_d == ASSERT);
        req_pending_d  = (state_d == ARMED) || (state_d == ASSERT);
    end

    // FSM state, cooldown counter, statistics and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            hold_q         <= '0;
            dropped_q      <= '0;
            pass_request_q <= 1'b0;
            req_pending_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_q         <= hold_d;
            dropped_q      <= dropped_d;
            pass_request_q <= pass_request_d;
            req_pending_q  <= req_pending_d;
        end
    end

    assign pass_request = pass_request_q;
    assign req_pending  = req_pending_q;
    assign dropped_cnt  = dropped_q;

endmodule

// File: tb/tb_ped_request_ctrl.sv
// Bench for ped_request_ctrl: directed scenarios followed by a random phase,
// every cycle compared against a behavioural model of the request rules.
module tb_ped_request_ctrl;

    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int SG   = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_raw;
    logic       green;
    logic [7:0] clock_v;
    logic       pass_request;
    logic       req_pending;
    logic [7:0] dropped_cnt;

    int n_cmp = 0;
    int n_err = 0;
    bit saw_pass = 0;

    ped_request_ctrl #(
        .DEB_CYCLES     (DEB),
        .HOLDOFF_CYCLES (HOLD),
        .SHORT_GREEN    (SG)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_raw      (btn_raw),
        .green        (green),
        .clock        (clock_v),
        .pass_request (pass_request),
        .req_pending  (req_pending),
        .dropped_cnt  (dropped_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: button pipeline as a history of synchronised samples,
    // request handshake as flags plus a remaining-cooldown count.
    bit m_s1 = 0, m_s2 = 0, m_stable = 0, m_press = 0;
    bit m_hist[$];
    bit m_armed = 0, m_assert = 0;
    int m_hold = 0;
    int m_drop = 0;

    task automatic model_edge();
        int diff;
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_stable = 0; m_press = 0; m_hist.delete();
            m_armed = 0; m_assert = 0; m_hold = 0; m_drop = 0;
            return;
        end
        // request handshake reacts to the press pulse visible before this edge
        if (m_press && (m_armed || m_assert || m_hold > 0) && m_drop < 255) m_drop++;
        if (m_assert) begin
            if (!green || clock_v <= SG) begin m_assert = 0; m_hold = HOLD; end
        end else if (m_armed) begin
            if (green) begin m_armed = 0; m_assert = 1; end
        end else if (m_hold > 0) begin
            m_hold--;
        end else if (m_press) begin
            if (green) m_assert = 1; else m_armed = 1;
        end
        // a level is accepted after DEB consecutive synchronised samples disagree
        m_hist.push_back(m_s2);
        if (m_hist.size() > DEB) void'(m_hist.pop_front());
        diff = 0;
        foreach (m_hist[i]) if (m_hist[i] != m_stable) diff++;
        m_press = 0;
        if (diff == DEB) begin
            m_stable = !m_stable;
            m_press  = m_stable;
            m_hist.delete();
        end
        m_s2 = m_s1;
        m_s1 = btn_raw;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_pass_request", {31'b0, pass_request}, {31'b0, m_assert});
        chk("model_req_pending", {31'b0, req_pending}, {31'b0, (m_armed | m_assert)});
        chk("model_dropped_cnt", {24'b0, dropped_cnt}, m_drop);
        if (pass_request === 1'b1) saw_pass = 1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1; btn_raw = 1'b0; green = 1'b0; clock_v = 8'd0;
        steps(2);
        chk("reset_pass", {31'b0, pass_request}, 0);
        chk("reset_pending", {31'b0, req_pending}, 0);
        chk("reset_dropped", {24'b0, dropped_cnt}, 0);
        rst = 1'b0;
        steps(3);

        // clean press during a long green
        green = 1'b1; clock_v = 8'd50; btn_raw = 1'b1;
        steps(6);
        chk("s1_pass_before", {31'b0, pass_request}, 0);
        step();
        chk("s1_pass_asserted", {31'b0, pass_request}, 1);
        steps(3);
        btn_raw = 1'b0;
        steps(2);
        chk("s1_pass_held", {31'b0, pass_request}, 1);
        clock_v = 8'd10;
        step();
        chk("s1_pass_shortened", {31'b0, pass_request}, 0);
        steps(25);

        // bouncing contact never settles long enough
        saw_pass = 0;
        for (int i = 0; i < 10; i++) begin
            btn_raw = (i % 2 == 0);
            steps(2);
        end
        btn_raw = 1'b0;
        steps(10);
        chk("s2_no_pass", {31'b0, saw_pass}, 0);
        chk("s2_dropped", {24'b0, dropped_cnt}, 0);

        // press on red waits for green
        green = 1'b0; clock_v = 8'd40; btn_raw = 1'b1;
        steps(7);
        chk("s3_pending", {31'b0, req_pending}, 1);
        chk("s3_pass_wait", {31'b0, pass_request}, 0);
        btn_raw = 1'b0;
        steps(3);
        green = 1'b1;
        step();
        chk("s3_pass_on_green", {31'b0, pass_request}, 1);
        steps(3);
        green = 1'b0;
        step();
        chk("s3_pass_green_end", {31'b0, pass_request}, 0);
        steps(25);

        // three presses timed to land inside the cooldown
        green = 1'b1; clock_v = 8'd50; btn_raw = 1'b1;
        steps(8);
        btn_raw = 1'b0;
        steps(6);
        btn_raw = 1'b1; steps(4);
        btn_raw = 1'b0; steps(1);
        clock_v = 8'd10;
        step();
        chk("s4_pass_end", {31'b0, pass_request}, 0);
        steps(2);
        btn_raw = 1'b1; steps(4);
        btn_raw = 1'b0; steps(4);
        btn_raw = 1'b1; steps(4);
        btn_raw = 1'b0; steps(10);
        chk("s4_dropped", {24'b0, dropped_cnt}, 3);
        chk("s4_pending", {31'b0, req_pending}, 0);

        // reset while asserting, button held through release
        clock_v = 8'd50; btn_raw = 1'b1;
        steps(8);
        chk("s5_pass_before_rst", {31'b0, pass_request}, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("s5_pass_rst", {31'b0, pass_request}, 0);
        chk("s5_pending_rst", {31'b0, req_pending}, 0);
        chk("s5_dropped_rst", {24'b0, dropped_cnt}, 0);
        steps(6);
        chk("s5_pass_redebounce", {31'b0, pass_request}, 0);
        step();
        chk("s5_pass_again", {31'b0, pass_request}, 1);
        btn_raw = 1'b0; clock_v = 8'd5;
        steps(25);

        // counter saturation while armed on a permanent red
        green = 1'b0; clock_v = 8'd50;
        for (int i = 0; i < 301; i++) begin
            btn_raw = 1'b1; steps(4);
            btn_raw = 1'b0; steps(4);
        end
        chk("s6_saturated", {24'b0, dropped_cnt}, 255);
        chk("s6_armed", {31'b0, req_pending}, 1);
        rst = 1'b1; step(); rst = 1'b0;

        // random phase
        for (int seg = 0; seg < 300; seg++) begin
            btn_raw = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) green = ~green;
            if ($urandom_range(0, 2) == 0) clock_v = 8'($urandom_range(0, 40));
            rst = ($urandom_range(0, 59) == 0);
            steps($urandom_range(1, 10));
        end
        rst = 1'b0;
        steps(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
